// File: rtl/axi_arb_pkg.sv
// Shared types for the two-requester AXI4 write arbiter.
package axi_arb_pkg;

  localparam int unsigned REQ_W = 1;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } aw_state_t;

endpackage

// File: rtl/arb_order_fifo.sv
// Small synchronous FIFO of requester IDs recording grant order.
module arb_order_fifo
  import axi_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             push,
  input  logic [REQ_W-1:0] din,
  input  logic             pop,
  output logic [REQ_W-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [REQ_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wptr;
  logic [PW-1:0]    rptr;
  logic [CW-1:0]    count;
  logic             do_push;
  logic             do_pop;

  // full is taken from the registered count, so a pop never frees a slot
  // for a push in the same cycle.
  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rptr];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (do_push) wptr <= wptr + PW'(1);
      if (do_pop)  rptr <= rptr + PW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr] <= din;
  end

endmodule

// File: rtl/axi_wr_arb2.sv
// Two-to-one AXI4 write arbiter: round-robin AW grant per burst, W and B
// routed in grant order through order FIFOs.
module axi_wr_arb2
  import axi_arb_pkg::*;
#(
  parameter int unsigned DW      = 512,
  parameter int unsigned AW      = 20,
  parameter int unsigned MAX_OUT = 8
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [AW-1:0]   S0_AWADDR,
  input  logic [7:0]      S0_AWLEN,
  input  logic            S0_AWVALID,
  output logic            S0_AWREADY,
  input  logic [DW-1:0]   S0_WDATA,
  input  logic [DW/8-1:0] S0_WSTRB,
  input  logic            S0_WLAST,
  input  logic            S0_WVALID,
  output logic            S0_WREADY,
  output logic [1:0]      S0_BRESP,
  output logic            S0_BVALID,
  input  logic            S0_BREADY,
  input  logic [AW-1:0]   S1_AWADDR,
  input  logic [7:0]      S1_AWLEN,
  input  logic            S1_AWVALID,
  output logic            S1_AWREADY,
  input  logic [DW-1:0]   S1_WDATA,
  input  logic [DW/8-1:0] S1_WSTRB,
  input  logic            S1_WLAST,
  input  logic            S1_WVALID,
  output logic            S1_WREADY,
  output logic [1:0]      S1_BRESP,
  output logic            S1_BVALID,
  input  logic            S1_BREADY,
  output logic [AW-1:0]   M_AXI_AWADDR,
  output logic [7:0]      M_AXI_AWLEN,
  output logic            M_AXI_AWVALID,
  input  logic            M_AXI_AWREADY,
  output logic [DW-1:0]   M_AXI_WDATA,
  output logic [DW/8-1:0] M_AXI_WSTRB,
  output logic            M_AXI_WLAST,
  output logic            M_AXI_WVALID,
  input  logic            M_AXI_WREADY,
  input  logic [1:0]      M_AXI_BRESP,
  input  logic            M_AXI_BVALID,
  output logic            M_AXI_BREADY
);

  aw_state_t        state;
  aw_state_t        state_nxt;
  logic [REQ_W-1:0] last_grant;
  logic [REQ_W-1:0] gnt_id;
  logic             grant;
  logic [REQ_W-1:0] w_head;
  logic [REQ_W-1:0] b_head;
  logic             wempty, wfull, bempty, bfull;
  logic             w_pop, b_pop;

  always_ff @(posedge clk) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant) state_nxt = ISSUE;
      ISSUE:   if (M_AXI_AWREADY) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant depends only on registered state and requester inputs, never on
  // M_AXI_AWREADY.
  always_comb begin
    grant      = 1'b0;
    gnt_id     = '0;
    S0_AWREADY = 1'b0;
    S1_AWREADY = 1'b0;
    if (state == IDLE && resetn && !wfull && !bfull && (S0_AWVALID || S1_AWVALID)) begin
      grant = 1'b1;
      if (S0_AWVALID && S1_AWVALID) gnt_id = ~last_grant;
      else                          gnt_id = S1_AWVALID;
      S0_AWREADY = (gnt_id == 1'b0);
      S1_AWREADY = (gnt_id == 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      M_AXI_AWVALID <= 1'b0;
      last_grant    <= 1'b1;
    end else if (grant) begin
      M_AXI_AWVALID <= 1'b1;
      last_grant    <= gnt_id;
    end else if (state == ISSUE && M_AXI_AWREADY) begin
      M_AXI_AWVALID <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (grant) begin
      M_AXI_AWADDR <= gnt_id ? S1_AWADDR : S0_AWADDR;
      M_AXI_AWLEN  <= gnt_id ? S1_AWLEN  : S0_AWLEN;
    end
  end

  arb_order_fifo #(.DEPTH(MAX_OUT)) u_w_order (
    .clk    (clk),
    .resetn (resetn),
    .push   (grant),
    .din    (gnt_id),
    .pop    (w_pop),
    .dout   (w_head),
    .empty  (wempty),
    .full   (wfull)
  );

  arb_order_fifo #(.DEPTH(MAX_OUT)) u_b_order (
    .clk    (clk),
    .resetn (resetn),
    .push   (grant),
    .din    (gnt_id),
    .pop    (b_pop),
    .dout   (b_head),
    .empty  (bempty),
    .full   (bfull)
  );

  assign M_AXI_WDATA  = w_head ? S1_WDATA : S0_WDATA;
  assign M_AXI_WSTRB  = w_head ? S1_WSTRB : S0_WSTRB;
  assign M_AXI_WLAST  = w_head ? S1_WLAST : S0_WLAST;
  assign M_AXI_WVALID = (w_head ? S1_WVALID : S0_WVALID) & ~wempty;
  assign S0_WREADY    = M_AXI_WREADY & ~wempty & (w_head == 1'b0);
  assign S1_WREADY    = M_AXI_WREADY & ~wempty & (w_head == 1'b1);
  assign w_pop        = M_AXI_WVALID & M_AXI_WREADY & M_AXI_WLAST;

  // A response arriving with nothing outstanding is left unacknowledged.
  assign S0_BRESP     = M_AXI_BRESP;
  assign S1_BRESP     = M_AXI_BRESP;
  assign S0_BVALID    = M_AXI_BVALID & ~bempty & (b_head == 1'b0);
  assign S1_BVALID    = M_AXI_BVALID & ~bempty & (b_head == 1'b1);
  assign M_AXI_BREADY = (b_head ? S1_BREADY : S0_BREADY) & ~bempty;
  assign b_pop        = M_AXI_BVALID & M_AXI_BREADY;

endmodule

// File: tb/tb_axi_wr_arb2.sv
// Scoreboard bench for axi_wr_arb2: requester/slave models, grant-order
// expectations queued at AW acceptance and compared at W/B delivery.
module tb_axi_wr_arb2;

  localparam int unsigned DW = 32;
  localparam int unsigned AW = 20;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned MAX_OUT = 8;

  typedef struct {
    int unsigned id;
    int unsigned tag;
    logic [AW-1:0] addr;
    logic [7:0] len;
  } burst_t;

  typedef struct {
    int unsigned id;
    logic [1:0] resp;
  } bexp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] s_awaddr [2];
  logic [7:0]    s_awlen  [2];
  logic          s_awvalid[2];
  logic          s_awready[2];
  logic [DW-1:0] s_wdata  [2];
  logic [SW-1:0] s_wstrb  [2];
  logic          s_wlast  [2];
  logic          s_wvalid [2];
  logic          s_wready [2];
  logic [1:0]    s_bresp  [2];
  logic          s_bvalid [2];
  logic          s_bready [2];

  logic [AW-1:0] m_awaddr;
  logic [7:0]    m_awlen;
  logic          m_awvalid, m_awready;
  logic [DW-1:0] m_wdata;
  logic [SW-1:0] m_wstrb;
  logic          m_wlast, m_wvalid, m_wready;
  logic [1:0]    m_bresp;
  logic          m_bvalid, m_bready;

  axi_wr_arb2 #(.DW(DW), .AW(AW), .MAX_OUT(MAX_OUT)) dut (
    .clk(clk), .resetn(resetn),
    .S0_AWADDR(s_awaddr[0]), .S0_AWLEN(s_awlen[0]), .S0_AWVALID(s_awvalid[0]), .S0_AWREADY(s_awready[0]),
    .S0_WDATA(s_wdata[0]), .S0_WSTRB(s_wstrb[0]), .S0_WLAST(s_wlast[0]), .S0_WVALID(s_wvalid[0]),
    .S0_WREADY(s_wready[0]), .S0_BRESP(s_bresp[0]), .S0_BVALID(s_bvalid[0]), .S0_BREADY(s_bready[0]),
    .S1_AWADDR(s_awaddr[1]), .S1_AWLEN(s_awlen[1]), .S1_AWVALID(s_awvalid[1]), .S1_AWREADY(s_awready[1]),
    .S1_WDATA(s_wdata[1]), .S1_WSTRB(s_wstrb[1]), .S1_WLAST(s_wlast[1]), .S1_WVALID(s_wvalid[1]),
    .S1_WREADY(s_wready[1]), .S1_BRESP(s_bresp[1]), .S1_BVALID(s_bvalid[1]), .S1_BREADY(s_bready[1]),
    .M_AXI_AWADDR(m_awaddr), .M_AXI_AWLEN(m_awlen), .M_AXI_AWVALID(m_awvalid), .M_AXI_AWREADY(m_awready),
    .M_AXI_WDATA(m_wdata), .M_AXI_WSTRB(m_wstrb), .M_AXI_WLAST(m_wlast), .M_AXI_WVALID(m_wvalid),
    .M_AXI_WREADY(m_wready), .M_AXI_BRESP(m_bresp), .M_AXI_BVALID(m_bvalid), .M_AXI_BREADY(m_bready)
  );

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  // Knobs steering the requester and slave models.
  int unsigned aw_pct = 100, wv_pct = 100, br_pct = 100, awr_pct = 100, wr_pct = 100;
  bit          aw_force_low = 1'b0;
  int unsigned b_credit = 32'h4000_0000;

  burst_t      aw_q[2][$];
  burst_t      w_q[2][$];
  burst_t      aw_exp[$];
  burst_t      w_exp[$];
  bexp_t       b_exp[$];
  logic        gnt_seq[$];

  int unsigned wbeat[2];
  int unsigned ebeat, grant_cnt, bdone, wdone, awdone, b_issued, tot_beats, s1_spur;
  int unsigned cyc = 0, g_cyc = 0, b_cyc = 0, tag_ctr = 0;
  logic        model_last;
  logic        aw_hs[2], w_hs[2], b_hs[2];
  logic        m_aw_hs, m_w_hs, m_b_hs;

  task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mkdata(input int unsigned id, input int unsigned tag, input int unsigned beat);
    return {4'(id), 12'(tag), 16'(beat)};
  endfunction

  function automatic logic [SW-1:0] mkstrb(input int unsigned tag, input int unsigned beat);
    return SW'(tag ^ (beat * 3));
  endfunction

  task automatic clear_all();
    for (int n = 0; n < 2; n++) begin
      s_awvalid[n] = 1'b0; s_wvalid[n] = 1'b0; s_bready[n] = 1'b0;
      s_awaddr[n] = '0; s_awlen[n] = '0; s_wdata[n] = '0; s_wstrb[n] = '0; s_wlast[n] = 1'b0;
      aw_q[n].delete(); w_q[n].delete();
      wbeat[n] = 0; aw_hs[n] = 1'b0; w_hs[n] = 1'b0; b_hs[n] = 1'b0;
    end
    m_awready = 1'b0; m_wready = 1'b0; m_bvalid = 1'b0; m_bresp = '0;
    m_aw_hs = 1'b0; m_w_hs = 1'b0; m_b_hs = 1'b0;
    aw_exp.delete(); w_exp.delete(); b_exp.delete(); gnt_seq.delete();
    ebeat = 0; grant_cnt = 0; bdone = 0; wdone = 0; awdone = 0; b_issued = 0; tot_beats = 0;
    model_last = 1'b1;
  endtask

  task automatic monitor();
    logic   win, exp_win;
    burst_t b;
    bexp_t  e;
    for (int n = 0; n < 2; n++) begin
      aw_hs[n] = s_awvalid[n] & s_awready[n];
      w_hs[n]  = s_wvalid[n] & s_wready[n];
      b_hs[n]  = s_bvalid[n] & s_bready[n];
    end
    m_aw_hs = m_awvalid & m_awready;
    m_w_hs  = m_wvalid & m_wready;
    m_b_hs  = m_bvalid & m_bready;
    if (s_awready[1] | s_wready[1] | s_bvalid[1]) s1_spur++;

    if (aw_hs[0] | aw_hs[1]) begin
      chk("aw_one", 64'(aw_hs[0] & aw_hs[1]), 64'd0);
      win     = aw_hs[1];
      exp_win = (s_awvalid[0] & s_awvalid[1]) ? ~model_last : s_awvalid[1];
      chk("gnt", 64'(win), 64'(exp_win));
      chk("out_lim", 64'((grant_cnt - bdone) < MAX_OUT), 64'd1);
      b = aw_q[win][0];
      aw_exp.push_back(b);
      w_exp.push_back(b);
      e.id = b.id; e.resp = 2'(grant_cnt);
      b_exp.push_back(e);
      model_last = win;
      gnt_seq.push_back(win);
      grant_cnt++;
      g_cyc = cyc;
    end

    if (m_aw_hs) begin
      if (aw_exp.size() == 0) chk("aw_unexp", 64'd1, 64'd0);
      else begin
        b = aw_exp.pop_front();
        chk("awaddr", 64'(m_awaddr), 64'(b.addr));
        chk("awlen", 64'(m_awlen), 64'(b.len));
      end
      awdone++;
    end

    if (m_w_hs) begin
      chk("w_route", 64'(w_hs[0] | w_hs[1]), 64'd1);
      if (w_exp.size() == 0) chk("w_unexp", 64'd1, 64'd0);
      else begin
        b = w_exp[0];
        chk("wdata", 64'(m_wdata), 64'(mkdata(b.id, b.tag, ebeat)));
        chk("wstrb", 64'(m_wstrb), 64'(mkstrb(b.tag, ebeat)));
        chk("wlast", 64'(m_wlast), 64'(ebeat == b.len));
        tot_beats++;
        if (m_wlast) begin
          void'(w_exp.pop_front());
          ebeat = 0;
          wdone++;
        end else ebeat++;
      end
    end

    if (m_b_hs | b_hs[0] | b_hs[1]) begin
      chk("b_route", 64'(m_b_hs), 64'(b_hs[0] | b_hs[1]));
      chk("b_one", 64'(b_hs[0] & b_hs[1]), 64'd0);
      if (b_hs[0] | b_hs[1]) begin
        if (b_exp.size() == 0) chk("b_unexp", 64'd1, 64'd0);
        else begin
          e = b_exp.pop_front();
          chk("bid", 64'(b_hs[1]), 64'(e.id));
          chk("bresp", 64'(s_bresp[b_hs[1]]), 64'(e.resp));
        end
        bdone++;
        b_cyc = cyc;
      end
    end
  endtask

  task automatic drive();
    burst_t b;
    for (int n = 0; n < 2; n++) begin
      if (aw_hs[n]) begin
        void'(aw_q[n].pop_front());
        s_awvalid[n] = 1'b0;
      end
      if (!s_awvalid[n] && aw_q[n].size() > 0 && $urandom_range(99) < aw_pct) begin
        s_awaddr[n]  = aw_q[n][0].addr;
        s_awlen[n]   = aw_q[n][0].len;
        s_awvalid[n] = 1'b1;
      end
      if (w_hs[n]) begin
        if (wbeat[n] == 32'(w_q[n][0].len)) begin
          void'(w_q[n].pop_front());
          wbeat[n] = 0;
        end else wbeat[n]++;
        s_wvalid[n] = 1'b0;
      end
      if (!s_wvalid[n] && w_q[n].size() > 0 && $urandom_range(99) < wv_pct) begin
        b = w_q[n][0];
        s_wdata[n]  = mkdata(n, b.tag, wbeat[n]);
        s_wstrb[n]  = mkstrb(b.tag, wbeat[n]);
        s_wlast[n]  = (wbeat[n] == 32'(b.len));
        s_wvalid[n] = 1'b1;
      end
      s_bready[n] = ($urandom_range(99) < br_pct);
    end
    m_awready = !aw_force_low && ($urandom_range(99) < awr_pct);
    m_wready  = ($urandom_range(99) < wr_pct);
    if (m_b_hs) m_bvalid = 1'b0;
    if (!m_bvalid && b_credit > 0 && b_issued < wdone && b_issued < awdone) begin
      m_bvalid = 1'b1;
      m_bresp  = 2'(b_issued);
      b_issued++;
      b_credit--;
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (resetn) monitor();
      @(posedge clk);
      #1;
      if (!resetn) clear_all();
      else drive();
    end
  end

  task automatic step();
    @(posedge clk);
    #3;
  endtask

  task automatic push_burst(input int unsigned n, input logic [AW-1:0] addr, input logic [7:0] len);
    burst_t b;
    b.id = n; b.tag = tag_ctr; b.addr = addr; b.len = len;
    tag_ctr++;
    aw_q[n].push_back(b);
    w_q[n].push_back(b);
  endtask

  function automatic bit idle();
    return aw_q[0].size() == 0 && aw_q[1].size() == 0 && w_q[0].size() == 0 && w_q[1].size() == 0 &&
           aw_exp.size() == 0 && w_exp.size() == 0 && b_exp.size() == 0 && !m_bvalid;
  endfunction

  task automatic drain(input string tag, input int unsigned budget);
    int unsigned i = 0;
    while (!idle() && i < budget) begin step(); i++; end
    chk(tag, 64'(idle()), 64'd1);
  endtask

  task automatic wait_grants(input string tag, input int unsigned target, input int unsigned budget);
    int unsigned i = 0;
    while (grant_cnt < target && i < budget) begin step(); i++; end
    chk(tag, 64'(grant_cnt >= target), 64'd1);
  endtask

  initial begin
    int unsigned g0, bd0, tb0, exp_beats, i;
    logic [AW-1:0] exp_addr;
    logic [7:0]    exp_len;

    repeat (4) step();
    resetn = 1'b1;
    step();
    chk("rst_awvalid", 64'(m_awvalid), 64'd0);
    chk("rst_awready", 64'(s_awready[0] | s_awready[1]), 64'd0);
    chk("rst_wvalid", 64'(m_wvalid), 64'd0);
    chk("rst_bready", 64'(m_bready), 64'd0);

    // Single S0 burst with an always-ready slave.
    s1_spur = 0;
    push_burst(0, 20'h01000, 8'd63);
    wait_grants("t1_grant", 1, 50);
    chk("t1_awaddr", 64'(m_awaddr), 64'h1000);
    chk("t1_awvalid", 64'(m_awvalid), 64'd1);
    drain("t1_drain", 500);
    chk("t1_beats", 64'(tot_beats), 64'd64);
    chk("t1_bcount", 64'(bdone), 64'd1);
    chk("t1_s1_quiet", 64'(s1_spur), 64'd0);

    // Simultaneous requests; last grant was S0 so S1 wins the first tie.
    gnt_seq.delete();
    for (int k = 0; k < 8; k++) begin
      push_burst(0, 20'(32'h2000 + k * 16), 8'($urandom_range(0, 7)));
      push_burst(1, 20'(32'h8000 + k * 16), 8'($urandom_range(0, 7)));
    end
    drain("t2_drain", 2000);
    chk("t2_count", 64'(gnt_seq.size()), 64'd16);
    if (gnt_seq.size() == 16) begin
      chk("t2_first", 64'(gnt_seq[0]), 64'd1);
      for (int k = 1; k < 16; k++) chk("t2_alt", 64'(gnt_seq[k] ^ gnt_seq[k-1]), 64'd1);
    end

    // AWREADY held low while the granted address sits in ISSUE.
    aw_force_low = 1'b1;
    g0 = grant_cnt;
    push_burst(0, 20'h02340, 8'd3);
    push_burst(1, 20'h05550, 8'd2);
    wait_grants("t3_grant", g0 + 1, 50);
    exp_addr = (gnt_seq[$] == 1'b1) ? 20'h05550 : 20'h02340;
    exp_len  = (gnt_seq[$] == 1'b1) ? 8'd2 : 8'd3;
    for (int k = 0; k < 10; k++) begin
      chk("t3_awvalid", 64'(m_awvalid), 64'd1);
      chk("t3_awaddr", 64'(m_awaddr), 64'(exp_addr));
      chk("t3_awlen", 64'(m_awlen), 64'(exp_len));
      chk("t3_no_awready", 64'(s_awready[0] | s_awready[1]), 64'd0);
      step();
    end
    aw_force_low = 1'b0;
    drain("t3_drain", 200);

    // Outstanding limit: no B returned, ninth burst must wait.
    b_credit = 0;
    g0 = grant_cnt;
    for (int k = 0; k < 9; k++) push_burst(0, 20'(32'h30000 + k * 64), 8'd0);
    repeat (60) step();
    chk("t4_stall_cnt", 64'(grant_cnt - g0), 64'd8);
    chk("t4_stall_valid", 64'(s_awvalid[0]), 64'd1);
    chk("t4_stall_ready", 64'(s_awready[0]), 64'd0);
    bd0 = bdone;
    b_credit = 1;
    i = 0;
    while (bdone == bd0 && i < 50) begin step(); i++; end
    chk("t4_b_back", 64'(bdone - bd0), 64'd1);
    repeat (3) step();
    chk("t4_regrant_cnt", 64'(grant_cnt - g0), 64'd9);
    chk("t4_regrant_lat", 64'(g_cyc - b_cyc), 64'd1);
    b_credit = 32'h4000_0000;
    drain("t4_drain", 300);

    // Random backpressure on every channel, 200 random-length bursts.
    aw_pct = 50; wv_pct = 70; br_pct = 60; awr_pct = 60; wr_pct = 60;
    g0 = grant_cnt; bd0 = bdone; tb0 = tot_beats; exp_beats = 0;
    for (int k = 0; k < 100; k++) begin
      for (int n = 0; n < 2; n++) begin
        exp_len = 8'($urandom_range(0, 15));
        exp_beats += 32'(exp_len) + 1;
        push_burst(n, 20'($urandom), exp_len);
      end
    end
    drain("t5_drain", 30000);
    chk("t5_grants", 64'(grant_cnt - g0), 64'd200);
    chk("t5_bresps", 64'(bdone - bd0), 64'd200);
    chk("t5_beats", 64'(tot_beats - tb0), 64'(exp_beats));
    aw_pct = 100; wv_pct = 100; br_pct = 100; awr_pct = 100; wr_pct = 100;

    // Reset in the middle of a W burst, then a fresh S1 request.
    tb0 = tot_beats;
    push_burst(0, 20'h04000, 8'd31);
    i = 0;
    while (tot_beats - tb0 < 5 && i < 100) begin step(); i++; end
    chk("t6_midburst", 64'(tot_beats - tb0 >= 5), 64'd1);
    resetn = 1'b0;
    step();
    chk("t6_awvalid", 64'(m_awvalid), 64'd0);
    chk("t6_wvalid", 64'(m_wvalid), 64'd0);
    chk("t6_wready", 64'(s_wready[0] | s_wready[1]), 64'd0);
    chk("t6_awready", 64'(s_awready[0] | s_awready[1]), 64'd0);
    chk("t6_bready", 64'(m_bready), 64'd0);
    step();
    resetn = 1'b1;
    push_burst(1, 20'h07770, 8'd4);
    drain("t6_drain", 200);
    chk("t6_grants", 64'(gnt_seq.size()), 64'd1);
    if (gnt_seq.size() > 0) chk("t6_gnt_id", 64'(gnt_seq[0]), 64'd1);
    chk("t6_beats", 64'(tot_beats), 64'd5);
    chk("t6_bresps", 64'(bdone), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/axi_wr_arb2.md
Name: axi_wr_arb2

Overview:
- Two-to-one AXI4 write-channel arbiter (AW/W/B only). Lets two burst masters share one AXI4 slave port, e.g. the RAM fill engine plus a host/DMA writer.
- Round-robin grant per burst on AW. W beats and B responses are routed in grant order through two small order FIFOs.
- Read channels are not handled by this block.

Parameters:
DW, 512, data width in bits (multiple of 8)
AW, 20, address width
MAX_OUT, 8, max granted bursts not yet B-acknowledged (power of 2, 2..64)

Ports:
clk  in  1  clock
resetn  in  1  sync active-low reset
Sn_AWADDR  in  AW  requester n (n=0,1) burst address
Sn_AWLEN  in  8  requester n burst length-1
Sn_AWVALID  in  1  requester n address valid
Sn_AWREADY  out  1  requester n address accepted
Sn_WDATA  in  DW  requester n write data
Sn_WSTRB  in  DW/8  requester n byte strobes
Sn_WLAST  in  1  requester n last beat
Sn_WVALID  in  1  requester n data valid
Sn_WREADY  out  1  requester n data ready
Sn_BRESP  out  2  response to requester n
Sn_BVALID  out  1  response valid to requester n
Sn_BREADY  in  1  requester n response ready
M_AXI_AWADDR  out  AW  granted address (registered)
M_AXI_AWLEN  out  8  granted length (registered)
M_AXI_AWVALID  out  1  registered address valid
M_AXI_AWREADY  in  1  slave address ready
M_AXI_WDATA/WSTRB/WLAST  out  DW/DW/8/1  muxed write data
M_AXI_WVALID  out  1  muxed data valid
M_AXI_WREADY  in  1  slave data ready
M_AXI_BRESP  in  2  slave response
M_AXI_BVALID  in  1  slave response valid
M_AXI_BREADY  out  1  muxed response ready

Behaviour:
- Reset: M_AXI_AWVALID=0, both Sn_AWREADY=0, both FIFOs empty, last_grant=1 (S0 wins the first tie). M_AXI_AWADDR and M_AXI_AWLEN are don't-care.
- AW FSM, state IDLE:
  - Grant when any Sn_AWVALID is high and neither FIFO is full.
  - Both valid: grant the requester != last_grant. Only one valid: grant it.
  - On grant, in the same cycle: Sn_AWREADY=1 (combinational, one cycle); latch Sn_AWADDR/AWLEN into the M_AXI regs; set M_AXI_AWVALID<=1; push n into both FIFOs; last_grant<=n; go to ISSUE.
- AW FSM, state ISSUE: hold M_AXI_AWADDR/AWLEN/AWVALID stable. On M_AXI_AWREADY, M_AXI_AWVALID<=0 and go to IDLE.
- AW FSM throughput: one grant per 2 cycles maximum. No combinational path from M_AXI_AWREADY to any Sn_AWREADY.
- W path, all combinational from the W-FIFO head h (valid when not empty):
  - M_AXI_WDATA/WSTRB/WLAST = Sh_*.
  - M_AXI_WVALID = Sh_WVALID & !wempty.
  - Sh_WREADY = M_AXI_WREADY & !wempty. The other requester's WREADY = 0.
  - Pop W FIFO on M_AXI_WVALID & M_AXI_WREADY & M_AXI_WLAST.
  - W beats may reach the slave before the matching AW is accepted downstream; this is legal AXI.
- W path, empty FIFO: all Sn_WREADY=0, M_AXI_WVALID=0. A requester sending W before its AW is granted stalls.
- B path, head b of the B FIFO:
  - Sb_BVALID = M_AXI_BVALID & !bempty; Sb_BRESP = M_AXI_BRESP.
  - M_AXI_BREADY = Sb_BREADY & !bempty.
  - Pop on the B handshake. The other requester's BVALID = 0.
- B path, BVALID with empty B FIFO (protocol error): BREADY stays 0; no state change.
- FIFO depth is MAX_OUT; count width is clog2(MAX_OUT)+1.
- full uses the registered count: a push is blocked when full even if a pop occurs the same cycle. A simultaneous push and pop when not full leaves count unchanged.
- The B FIFO being full blocks new grants. This bounds outstanding bursts to MAX_OUT.
- Reset mid-burst: all state clears next edge. Upstream and downstream must be reset together; partial bursts are not recovered.

Decomposition:
- Package axi_arb_pkg: REQ_W=1 requester-ID width; AW FSM state constants IDLE=0, ISSUE=1.
- Sub-module arb_order_fifo: sync FIFO of REQ_W-bit IDs with params DEPTH; ports clk, resetn, push, din, pop, dout, empty, full. Instantiated twice (W order, B order).

Test Plan:
- S0 alone, AWADDR=0x1000, AWLEN=63, M_AXI_AWREADY/WREADY tied 1 -> M_AXI_AWADDR=0x1000 one cycle after S0_AWREADY; 64 W beats routed; S0_BVALID with BRESP=0; S1 sees no ready/valid.
- S0 and S1 both raise AWVALID at the same cycle, repeatedly, 8 bursts each -> grants alternate S0,S1,S0,…; W beats and B responses delivered to the correct requester in grant order.
- M_AXI_AWREADY low for 10 cycles during ISSUE -> M_AXI_AWADDR/AWLEN/AWVALID stable for all 10; no second Sn_AWREADY issued.
- M_AXI_BREADY path stalled (BVALID never asserted) with MAX_OUT=8 -> exactly 8 grants, 9th AW stalls. Then one B returned -> 9th grant next cycle.
- Random WREADY/BREADY/AWREADY backpressure, 200 random-length bursts from both requesters -> beat counts per burst match AWLEN+1; no beat crosses a requester; every burst gets exactly one B.
- resetn pulsed low mid-W-burst -> next cycle M_AXI_AWVALID=0, M_AXI_WVALID=0, all Sn_READY=0, FIFOs empty; a fresh S1 request is granted after reset release.
